inst_axi_rd_bridge: RTL and testbench
=====================================

Name: inst_axi_rd_bridge

Overview:
- Sits directly upstream of if_stage, on the memory side.
- Acts as a slave on the instruction sram-like interface (req/addr_ok/data_ok) and as a master on an AXI3 read-only port (AR/R channels).
- Converts each accepted sram-like fetch into one single-beat AXI read.
- Returns data strictly in request order, with a bounded number of outstanding fetches.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-not-returned fetches (1..4).
- AXI_ID, 4'd0, constant arid driven on every read.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- inst_sram_req  input  1  fetch request from pre-IF
- inst_sram_wr  input  1  must be 0; ignored, every request is a read
- inst_sram_size  input  2  byte-size code, forwarded to arsize
- inst_sram_addr  input  32  fetch address
- inst_sram_wstrb  input  4  ignored
- inst_sram_wdata  input  32  ignored
- inst_sram_addrok  output  1  request accepted this cycle
- inst_sram_dataok  output  1  inst_sram_rdata valid this cycle
- inst_sram_rdata  output  32  returned instruction word
- arid  output  4  = AXI_ID
- araddr  output  32  latched fetch address
- arlen  output  8  constant 0
- arsize  output  3  {1'b0, latched size}
- arburst  output  2  constant 2'b01
- arlock  output  2  constant 0
- arcache  output  4  constant 0
- arprot  output  3  constant 0
- arvalid  output  1  AR request valid
- arready  input  1  AR accepted by slave
- rid  input  4  ignored (single ID, in-order)
- rdata  input  32  read data
- rresp  input  2  ignored
- rlast  input  1  ignored (single beat)
- rvalid  input  1  R beat valid
- rready  output  1  bridge accepts R beat

Behaviour:
- Reset values: arvalid=0, addrok=0, dataok=0, rready=0, araddr=0, arsize=0, rdata output=0, outstanding count=0, FSM in AR_IDLE.
- AR FSM:
  - AR_IDLE:
    - inst_sram_addrok = inst_sram_req && (cnt < MAX_OUTSTANDING), combinational.
    - On addrok, latch addr/size and go to AR_SEND.
  - AR_SEND:
    - arvalid=1; araddr/arsize are held stable.
    - On arready go to AR_IDLE.
    - addrok=0 in this state; a new request is accepted no earlier than the cycle after the arready handshake.
- Outstanding counter cnt, width clog2(MAX_OUTSTANDING+1):
  - +1 on addrok, −1 on the R handshake (rvalid && rready).
  - Both in the same cycle: unchanged.
  - cnt==MAX_OUTSTANDING: addrok held 0 even if req=1.
- rready = (cnt != 0). An rvalid arriving while cnt==0 is not accepted.
- Default response path (combinational):
  - inst_sram_dataok = rvalid && rready.
  - inst_sram_rdata = rdata.
  - Latency from the R handshake to dataok is 0 cycles.
- Ordering: dataok pulses exactly once per addrok, in acceptance order. No reordering; rid and rresp are not checked.
- Minimum fetch latency, arready=1 and rvalid in the cycle after the AR handshake: addrok in cycle 0, arvalid in cycle 1, dataok in cycle 2.
- Reset mid-transaction:
  - All state clears next edge, including arvalid dropping even if unaccepted.
  - Any in-flight R beats are dropped.
- Bridge has no flush input. if_stage is responsible for discarding stale data after an exception.

Optional Feature:
- Macro: INST_BRIDGE_RBUF_EN.
- When defined:
  - A one-entry registered response buffer is added.
  - R handshake requires rvalid && (buffer empty or being drained). The buffer always drains in the cycle after capture, since if_stage has no data backpressure.
  - The beat is captured; inst_sram_dataok/rdata are driven from the register one cycle later. Minimum fetch latency becomes 3 cycles.
  - cnt decrements on the buffered dataok, not on the R handshake.
  - Buffer valid and data are cleared on reset.
- When undefined: the combinational path above applies.

Test Plan:
- Single fetch:
  - Stimulus: req=1, addr=0xbfc00000, size=2; arready=1; rvalid=1 with rdata=0x3c1d0000 one cycle after arvalid.
  - Required: addrok in cycle 0; araddr=0xbfc00000 with arsize=3'd2 in cycle 1; dataok=1 with rdata=0x3c1d0000 in cycle 2.
- AR backpressure:
  - Stimulus: arready held 0 for 3 cycles.
  - Required: arvalid=1 with araddr stable for all 4 cycles; addrok=0 throughout.
- Outstanding limit (MAX_OUTSTANDING=2):
  - Stimulus: issue 0xbfc00000 and 0xbfc00004; rvalid held 0; req held 1.
  - Required: no third addrok. After one R beat, a new addrok occurs no earlier than the same cycle as that beat.
- In-order return:
  - Stimulus: two fetches; R beats 0x11111111 then 0x22222222.
  - Required: dataok twice, in that order; cnt returns to 0.
- Reset mid-flight:
  - Stimulus: assert reset while arvalid=1 and cnt=1.
  - Required: next cycle arvalid=0, rready=0, cnt=0. A stray rvalid afterwards produces no dataok.
- RBUF_EN build:
  - Stimulus: repeat the single-fetch scenario.
  - Required: dataok in cycle 3 with rdata=0x3c1d0000.

Source files
------------

// File: rtl/inst_axi_rd_bridge_if.sv
// Signal bundle between if_stage's sram-like fetch port, the read bridge and the AXI3 read channels.
// The bridge uses the master modport; the fetch side and the AXI slave together use the slave modport.
interface inst_axi_rd_bridge_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addrok;
  logic        inst_sram_dataok;
  logic [31:0] inst_sram_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
    input  inst_sram_wstrb, inst_sram_wdata,
    output inst_sram_addrok, inst_sram_dataok, inst_sram_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
    output inst_sram_wstrb, inst_sram_wdata,
    input  inst_sram_addrok, inst_sram_dataok, inst_sram_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-fetch bridge: sram-like read requests to single-beat in-order AXI3 reads.
// Define INST_BRIDGE_RBUF_EN to register the response path through a one-entry buffer.
module inst_axi_rd_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] AXI_ID          = 4'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_axi_rd_bridge_if.master  bus
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_SEND = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      araddr_q;
  logic [1:0]       arsize_q;
  logic             accept;
  logic             r_hs;
  logic             ret;

  assign accept = (state == AR_IDLE) && bus.inst_sram_req && (cnt < CNT_MAX);

  // AR request stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= AR_IDLE;
      araddr_q <= '0;
      arsize_q <= '0;
    end else begin
      case (state)
        AR_IDLE: if (accept) begin
          state    <= AR_SEND;
          araddr_q <= bus.inst_sram_addr;
          arsize_q <= bus.inst_sram_size;
        end
        AR_SEND: if (bus.arready) state <= AR_IDLE;
        default: state <= AR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      case ({accept, ret})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.inst_sram_addrok = accept;
  assign bus.arid    = AXI_ID;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, arsize_q};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = (state == AR_SEND);

`ifdef INST_BRIDGE_RBUF_EN
  logic             vld_p1;
  logic [31:0]      rdata_p1;
  logic [CNT_W-1:0] pend;

  // A buffered beat is still counted in cnt, but no longer owed on R.
  assign pend       = cnt - CNT_W'(vld_p1);
  assign bus.rready = (pend != '0);
  assign r_hs       = bus.rvalid && bus.rready;

  // Response buffer stage
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= r_hs;
      if (r_hs) rdata_p1 <= bus.rdata;
    end
  end

  assign ret                  = vld_p1;
  assign bus.inst_sram_dataok = vld_p1;
  assign bus.inst_sram_rdata  = rdata_p1;
`else
  assign bus.rready           = (cnt != '0);
  assign r_hs                 = bus.rvalid && bus.rready;
  assign ret                  = r_hs;
  assign bus.inst_sram_dataok = r_hs;
  assign bus.inst_sram_rdata  = bus.rdata;
`endif

  // Write-side fields, ID, response code and last flag carry no information for in-order single-beat reads.
  logic unused_in;
  assign unused_in = &{1'b0, bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata,
                       bus.rid, bus.rresp, bus.rlast};

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge; expected timings follow INST_BRIDGE_RBUF_EN when defined.
module tb_inst_axi_rd_bridge;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  inst_axi_rd_bridge_if bus ();

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .AXI_ID(4'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset                = 1'b1;
    bus.inst_sram_req    = 1'b0;
    bus.inst_sram_wr     = 1'b0;
    bus.inst_sram_size   = 2'd0;
    bus.inst_sram_addr   = 32'h0;
    bus.inst_sram_wstrb  = 4'h0;
    bus.inst_sram_wdata  = 32'h0;
    bus.arready          = 1'b0;
    bus.rid              = 4'd0;
    bus.rdata            = 32'h0;
    bus.rresp            = 2'd0;
    bus.rlast            = 1'b1;
    bus.rvalid           = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset;
    #1;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_addrok",  bus.inst_sram_addrok, 0);
    chk("rst_dataok",  bus.inst_sram_dataok, 0);
    chk("rst_rready",  bus.rready, 0);
    chk("rst_araddr",  bus.araddr, 32'h0);
    chk("rst_arsize",  bus.arsize, 0);
    chk("rst_rdata",   bus.inst_sram_rdata, 32'h0);
    chk("const_arlen", bus.arlen, 0);
    chk("const_arburst", bus.arburst, 2'b01);
    chk("const_arid",  bus.arid, 0);

    // Single fetch
    tick;
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'hbfc00000;
    bus.inst_sram_size = 2'd2;
    #1;
    chk("sf_addrok_c0", bus.inst_sram_addrok, 1);
    tick;
    bus.inst_sram_req = 1'b0;
    bus.arready       = 1'b1;
    #1;
    chk("sf_arvalid_c1", bus.arvalid, 1);
    chk("sf_araddr_c1",  bus.araddr, 32'hbfc00000);
    chk("sf_arsize_c1",  bus.arsize, 3'd2);
    tick;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h3c1d0000;
    #1;
    chk("sf_arvalid_c2", bus.arvalid, 0);
`ifdef INST_BRIDGE_RBUF_EN
    chk("sf_dataok_c2", bus.inst_sram_dataok, 0);
    tick;
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;
    #1;
    chk("sf_dataok_c3", bus.inst_sram_dataok, 1);
    chk("sf_rdata_c3",  bus.inst_sram_rdata, 32'h3c1d0000);
`else
    chk("sf_dataok_c2", bus.inst_sram_dataok, 1);
    chk("sf_rdata_c2",  bus.inst_sram_rdata, 32'h3c1d0000);
`endif
    tick;
    bus.rvalid = 1'b0;
    #1;
    chk("sf_rready_end", bus.rready, 0);
    chk("sf_dataok_end", bus.inst_sram_dataok, 0);

    // AR backpressure: arready low three cycles, then accepted
    do_reset;
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'h1000_0040;
    bus.inst_sram_size = 2'd1;
    #1;
    chk("bp_addrok_c0", bus.inst_sram_addrok, 1);
    tick;
    bus.inst_sram_addr = 32'h2000_0000;
    for (int i = 0; i < 4; i++) begin
      bus.arready = (i == 3);
      #1;
      chk($sformatf("bp_arvalid_%0d", i), bus.arvalid, 1);
      chk($sformatf("bp_araddr_%0d", i),  bus.araddr, 32'h1000_0040);
      chk($sformatf("bp_arsize_%0d", i),  bus.arsize, 3'd1);
      chk($sformatf("bp_addrok_%0d", i),  bus.inst_sram_addrok, 0);
      tick;
    end
    bus.inst_sram_req = 1'b0;
    bus.arready       = 1'b0;
    #1;
    chk("bp_arvalid_done", bus.arvalid, 0);

    // Outstanding limit
    do_reset;
    bus.arready        = 1'b1;
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'hbfc00000;
    bus.inst_sram_size = 2'd2;
    #1;
    chk("ol_addrok_a", bus.inst_sram_addrok, 1);
    tick;
    bus.inst_sram_addr = 32'hbfc00004;
    tick;
    #1;
    chk("ol_addrok_b", bus.inst_sram_addrok, 1);
    tick;
    #1;
    chk("ol_araddr_b", bus.araddr, 32'hbfc00004);
    tick;
    bus.inst_sram_addr = 32'hbfc00008;
    #1;
    chk("ol_addrok_full0", bus.inst_sram_addrok, 0);
    chk("ol_rready_full",  bus.rready, 1);
    tick;
    #1;
    chk("ol_addrok_full1", bus.inst_sram_addrok, 0);
    chk("ol_arvalid_full", bus.arvalid, 0);
    tick;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h11111111;
    #1;
`ifndef INST_BRIDGE_RBUF_EN
    chk("ol_dataok_beat", bus.inst_sram_dataok, 1);
`endif
    tick;
    bus.rvalid = 1'b0;
`ifdef INST_BRIDGE_RBUF_EN
    #1;
    chk("ol_dataok_beat", bus.inst_sram_dataok, 1);
    tick;
`endif
    #1;
    chk("ol_addrok_after", bus.inst_sram_addrok, 1);
    bus.inst_sram_req = 1'b0;

    // In-order return of two fetches
    do_reset;
    bus.arready        = 1'b1;
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'h0000_0100;
    #1;
    chk("io_addrok_a", bus.inst_sram_addrok, 1);
    tick;
    bus.inst_sram_addr = 32'h0000_0104;
    tick;
    #1;
    chk("io_addrok_b", bus.inst_sram_addrok, 1);
    tick;
    bus.inst_sram_req = 1'b0;
    tick;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h11111111;
    #1;
`ifndef INST_BRIDGE_RBUF_EN
    chk("io_dataok_1", bus.inst_sram_dataok, 1);
    chk("io_rdata_1",  bus.inst_sram_rdata, 32'h11111111);
`endif
    tick;
    bus.rdata = 32'h22222222;
    #1;
`ifdef INST_BRIDGE_RBUF_EN
    chk("io_dataok_1", bus.inst_sram_dataok, 1);
    chk("io_rdata_1",  bus.inst_sram_rdata, 32'h11111111);
`else
    chk("io_dataok_2", bus.inst_sram_dataok, 1);
    chk("io_rdata_2",  bus.inst_sram_rdata, 32'h22222222);
`endif
    tick;
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;
    #1;
`ifdef INST_BRIDGE_RBUF_EN
    chk("io_dataok_2", bus.inst_sram_dataok, 1);
    chk("io_rdata_2",  bus.inst_sram_rdata, 32'h22222222);
    tick;
`else
    chk("io_dataok_idle", bus.inst_sram_dataok, 0);
`endif
    chk("io_rready_end", bus.rready, 0);

    // Reset while an AR is pending
    do_reset;
    bus.inst_sram_req  = 1'b1;
    bus.inst_sram_addr = 32'hbfc00010;
    #1;
    chk("rm_addrok", bus.inst_sram_addrok, 1);
    tick;
    bus.inst_sram_req = 1'b0;
    #1;
    chk("rm_arvalid_pre", bus.arvalid, 1);
    chk("rm_rready_pre",  bus.rready, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("rm_arvalid_post", bus.arvalid, 0);
    chk("rm_rready_post",  bus.rready, 0);
    chk("rm_araddr_post",  bus.araddr, 32'h0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hdeadbeef;
    #1;
    chk("rm_stray_dataok0", bus.inst_sram_dataok, 0);
    tick;
    bus.rvalid = 1'b0;
    #1;
    chk("rm_stray_dataok1", bus.inst_sram_dataok, 0);
    chk("rm_rready_idle",   bus.rready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
